// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_XOR    = 4'h0,
        OP_AND    = 4'h1,
        OP_ADD    = 4'h2,
        OP_SLL    = 4'h3,
        OP_SRL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_SUB    = 4'h6,
        OP_OR     = 4'h7,
        OP_MUL    = 4'h8,
        OP_DIV    = 4'h9,
        OP_DIVU   = 4'hA,
        OP_REM    = 4'hB,
        OP_REMU   = 4'hC,
        OP_MULH   = 4'hD,
        OP_MULHSU = 4'hE,
        OP_MULHU  = 4'hF
    } alu_op_e;

    typedef logic [1:0] alu_state_e;
    localparam alu_state_e ST_IDLE = 2'd0;
    localparam alu_state_e ST_MUL  = 2'd1;
    localparam alu_state_e ST_DIV  = 2'd2;
    localparam alu_state_e ST_DONE = 2'd3;

    localparam int CMP_LT = 2;
    localparam int CMP_GT = 1;
    localparam int CMP_EQ = 0;

    function automatic logic is_mul(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring radix-2 divider: XLEN iterations on magnitudes, then one cycle
// in which the signed quotient/remainder is presented with done=1.
module alu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            signed_op,
    input  logic            rem_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_ITER = 2'd1;
    localparam logic [1:0] P_FIX  = 2'd2;

    logic [1:0]      phase;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q, r, d;
    logic            quo_neg, rem_neg, rem_sel_q;
    logic [XLEN:0]   sh, diff;

    // Partial remainder shifted left with the next dividend bit, minus divisor.
    assign sh   = {r, q[XLEN-1]};
    assign diff = sh - {1'b0, d};

    assign done   = (phase == P_FIX);
    assign result = rem_sel_q ? (rem_neg ? -r : r) : (quo_neg ? -q : q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= P_IDLE;
            cnt       <= '0;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (abort) begin
            phase <= P_IDLE;
        end else begin
            case (phase)
                P_IDLE: begin
                    if (start) begin
                        phase     <= P_ITER;
                        cnt       <= '0;
                        r         <= '0;
                        q         <= (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
                        d         <= (signed_op && divisor[XLEN-1]) ? -divisor : divisor;
                        quo_neg   <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        rem_neg   <= signed_op && dividend[XLEN-1];
                        rem_sel_q <= rem_sel;
                    end
                end
                P_ITER: begin
                    if (!diff[XLEN]) begin
                        r <= diff[XLEN-1:0];
                        q <= {q[XLEN-2:0], 1'b1};
                    end else begin
                        r <= sh[XLEN-1:0];
                        q <= {q[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) phase <= P_FIX;
                end
                default: phase <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift, pipelined
// multiply and iterative divide behind a valid/ready handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [3:0]      alu_operation_type,
    input  logic            comparison_mode,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [2:0]      comparison_flags,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state;
    alu_op_e         op, op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            mode_q;
    logic            accept, div_signed, div_ovf, div_start, div_done;
    logic            a_sgn, b_sgn;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] quick_res, div_res;
    logic signed [2*XLEN-1:0] mul_a, mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [2*XLEN-1:0] mul_pipe [MUL_STAGES];
    logic [MUL_STAGES-1:0] mul_vld;

    // Handshake: a transfer happens on any edge where valid and ready are both
    // high; flush in IDLE suppresses the transfer even though in_ready is 1.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    assign op         = alu_op_e'(alu_operation_type);
    assign accept     = in_valid && (state == ST_IDLE) && !flush;
    assign shamt      = alu_b[SW-1:0];
    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign div_ovf    = div_signed && (alu_a == MOST_NEG) && (alu_b == '1);
    assign div_start  = accept && is_div(op) && (alu_b != '0) && !div_ovf;

    // Sign-extending to 2*XLEN gives the same low 2*XLEN product bits as the
    // XLEN+1-bit extended multiply.
    assign a_sgn    = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_sgn    = (op == OP_MULH);
    assign mul_a    = {{XLEN{a_sgn & alu_a[XLEN-1]}}, alu_a};
    assign mul_b    = {{XLEN{b_sgn & alu_b[XLEN-1]}}, alu_b};
    assign mul_prod = mul_a * mul_b;

    function automatic logic [2:0] cmp_flags(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b,
                                             input logic uns);
        logic [2:0] f;
        f         = '0;
        f[CMP_LT] = uns ? (a < b) : ($signed(a) < $signed(b));
        f[CMP_GT] = uns ? (a > b) : ($signed(a) > $signed(b));
        f[CMP_EQ] = (a == b);
        return f;
    endfunction

    always_comb begin
        quick_res = '0;
        case (op)
            OP_XOR:  quick_res = alu_a ^ alu_b;
            OP_AND:  quick_res = alu_a & alu_b;
            OP_ADD:  quick_res = alu_a + alu_b;
            OP_SLL:  quick_res = alu_a << shamt;
            OP_SRL:  quick_res = alu_a >> shamt;
            OP_SRA:  quick_res = $signed(alu_a) >>> shamt;
            OP_SUB:  quick_res = alu_a - alu_b;
            OP_OR:   quick_res = alu_a | alu_b;
            // Only the zero-divisor and signed-overflow shortcuts land here.
            OP_DIV:  quick_res = div_ovf ? alu_a : '0;
            default: quick_res = '0;
        endcase
    end

    alu_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .signed_op (div_signed),
        .rem_sel   ((op == OP_REM) || (op == OP_REMU)),
        .dividend  (alu_a),
        .divisor   (alu_b),
        .done      (div_done),
        .result    (div_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            op_q             <= OP_XOR;
            a_q              <= '0;
            b_q              <= '0;
            mode_q           <= 1'b0;
            alu_result       <= '0;
            comparison_flags <= '0;
            mul_vld          <= '0;
            for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
        end else begin
            mul_vld[0] <= accept && is_mul(op);
            if (accept) mul_pipe[0] <= mul_prod;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_vld[i]  <= mul_vld[i-1] && !flush;
                mul_pipe[i] <= mul_pipe[i-1];
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        a_q    <= alu_a;
                        b_q    <= alu_b;
                        mode_q <= comparison_mode;
                        if (is_mul(op)) begin
                            state <= ST_MUL;
                        end else if (div_start) begin
                            state <= ST_DIV;
                        end else begin
                            state            <= ST_DONE;
                            alu_result       <= quick_res;
                            comparison_flags <= cmp_flags(alu_a, alu_b, comparison_mode);
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (mul_vld[MUL_STAGES-1]) begin
                        state            <= ST_DONE;
                        alu_result       <= (op_q == OP_MUL) ? mul_pipe[MUL_STAGES-1][XLEN-1:0]
                                                             : mul_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
                        comparison_flags <= cmp_flags(a_q, b_q, mode_q);
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        state            <= ST_DONE;
                        alu_result       <= div_res;
                        comparison_flags <= cmp_flags(a_q, b_q, mode_q);
                    end
                end
                default: begin
                    if (flush || out_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomised checks of alu_mc at XLEN=32, MUL_STAGES=2 against a
// behavioural reference model with a result/flag scoreboard.
module tb_alu_mc;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_operation_type;
    logic            comparison_mode;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic [2:0]      comparison_flags;
    logic            busy;

    logic [XLEN-1:0] exp_q[$];
    logic [2:0]      exp_fq[$];
    int              n_checks;
    int              n_pass;

    alu_mc #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .alu_a              (alu_a),
        .alu_b              (alu_b),
        .alu_operation_type (alu_operation_type),
        .comparison_mode    (comparison_mode),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .alu_result         (alu_result),
        .comparison_flags   (comparison_flags),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        logic        ovf;
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            4'h0: return a ^ b;
            4'h1: return a & b;
            4'h2: return a + b;
            4'h3: return a << sh;
            4'h4: return a >> sh;
            4'h5: return $signed(a) >>> sh;
            4'h6: return a - b;
            4'h7: return a | b;
            4'h8: begin p = a * b; return p[31:0]; end
            4'h9: begin
                if (b == 0) return 32'd0;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            4'hA: return (b == 0) ? 32'd0 : a / b;
            4'hB: begin
                if (b == 0 || ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            4'hC: return (b == 0) ? 32'd0 : a % b;
            4'hD: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            4'hE: begin
                p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
                return p[63:32];
            end
            default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [2:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                               input logic uns);
        logic lt, gt;
        lt = uns ? (a < b) : ($signed(a) < $signed(b));
        gt = uns ? (a > b) : ($signed(a) > $signed(b));
        return {lt, gt, a == b};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op == 4'h8 || op >= 4'hD) return 3;
        if (op >= 4'h9 && op <= 4'hC) begin
            if (b == 0) return 1;
            if ((op == 4'h9 || op == 4'hB) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_result"},    alu_result, 32'd0);
        check({tag, "_flags"},     32'(comparison_flags), 32'd0);
    endtask

    // Called just after a negedge with the DUT idle; returns at the first
    // negedge where out_valid is seen (or after the cycle budget).
    task automatic op_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic mode, input int exp_lat, input string tag);
        int lat;
        alu_operation_type = op;
        alu_a              = a;
        alu_b              = b;
        comparison_mode    = mode;
        in_valid           = 1'b1;
        exp_q.push_back(model_res(op, a, b));
        exp_fq.push_back(model_flags(a, b, mode));
        @(posedge clk);
        #1;
        in_valid           = 1'b0;
        alu_a              = $urandom();
        alu_b              = $urandom();
        alu_operation_type = 4'($urandom_range(0, 15));
        comparison_mode    = ~mode;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, alu_result, exp_q.pop_front());
        check({tag, "_flg"}, 32'(comparison_flags), 32'(exp_fq.pop_front()));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check({tag, "_ov0"}, 32'(out_valid), 32'd0);
    endtask

    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_mode;
    int          seen;

    initial begin
        n_checks           = 0;
        n_pass             = 0;
        rst_n              = 1'b0;
        in_valid           = 1'b0;
        flush              = 1'b0;
        out_ready          = 1'b1;
        alu_a              = '0;
        alu_b              = '0;
        alu_operation_type = '0;
        comparison_mode    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        op_wait(4'h2, 32'd5, 32'd7, 1'b0, 1, "add");
        check("add_flags_const", 32'(comparison_flags), 32'd4);
        handoff("add");

        op_wait(4'hD, 32'h8000_0000, 32'd2, 1'b0, 3, "mulh");
        check("mulh_const", alu_result, 32'hFFFF_FFFF);
        handoff("mulh");
        op_wait(4'hF, 32'h8000_0000, 32'd2, 1'b0, 3, "mulhu");
        handoff("mulhu");
        op_wait(4'h8, 32'h8000_0000, 32'd2, 1'b0, 3, "mul");
        handoff("mul");
        op_wait(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3, "mulhsu");
        handoff("mulhsu");

        op_wait(4'h9, -32'sd7, 32'd2, 1'b0, 34, "div");
        check("div_const", alu_result, 32'hFFFF_FFFD);
        handoff("div");
        op_wait(4'hB, -32'sd7, 32'd2, 1'b0, 34, "rem");
        handoff("rem");
        op_wait(4'hA, 32'd100, 32'd7, 1'b1, 34, "divu");
        handoff("divu");
        op_wait(4'hC, 32'd100, 32'd7, 1'b1, 34, "remu");
        handoff("remu");

        op_wait(4'hA, 32'd9, 32'd0, 1'b1, 1, "divu_zero");
        handoff("divu_zero");
        op_wait(4'h9, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, "div_ovf");
        check("div_ovf_const", alu_result, 32'h8000_0000);
        handoff("div_ovf");
        op_wait(4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, "rem_ovf");
        handoff("rem_ovf");
        op_wait(4'h5, 32'h8000_00F0, 32'hFFFF_FF24, 1'b0, 1, "sra");
        handoff("sra");

        // Backpressure: result held while a competing request is ignored.
        out_ready = 1'b0;
        op_wait(4'h0, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b0, 1, "xor_bp");
        alu_operation_type = 4'h2;
        alu_a              = 32'd1;
        alu_b              = 32'd2;
        in_valid           = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res", alu_result, 32'hAAAA_AAAA);
            check("bp_flg", 32'(comparison_flags), 32'(model_flags(32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b0)));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        handoff("bp");

        op_wait(4'h2, 32'hFFFF_FFFF, 32'd1, 1'b1, 1, "cmp_uns");
        check("cmp_uns_const", 32'(comparison_flags), 32'd2);
        handoff("cmp_uns");
        op_wait(4'h2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, "cmp_sgn");
        check("cmp_sgn_const", 32'(comparison_flags), 32'd4);
        handoff("cmp_sgn");

        for (int i = 0; i < 24; i++) begin
            r_op   = 4'($urandom_range(0, 15));
            r_a    = $urandom();
            r_b    = $urandom();
            r_mode = 1'($urandom_range(0, 1));
            if (i % 4 == 0) r_b = 32'($urandom_range(0, 3));
            if (i % 8 == 1) begin
                r_a = 32'h8000_0000;
                r_b = 32'hFFFF_FFFF;
            end
            op_wait(r_op, r_a, r_b, r_mode, model_lat(r_op, r_a, r_b), "rand");
            handoff("rand");
        end

        // Flush in IDLE beats accept.
        alu_operation_type = 4'h2;
        alu_a              = 32'd3;
        alu_b              = 32'd4;
        in_valid           = 1'b1;
        flush              = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_idle_rdy", 32'(in_ready), 32'd1);

        // Flush in DONE drops the pending result.
        out_ready = 1'b0;
        op_wait(4'h7, 32'h0000_F000, 32'h0000_000F, 1'b0, 1, "or_fl");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_ov", 32'(out_valid), 32'd0);
        check("flush_done_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Flush at cycle 10 of a divide.
        alu_operation_type = 4'h9;
        alu_a              = -32'sd7;
        alu_b              = 32'd2;
        in_valid           = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("div_mid_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_busy", 32'(busy), 32'd0);
        check("flush_div_rdy", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_div_no_out", 32'(seen), 32'd0);
        op_wait(4'h2, 32'd20, 32'd22, 1'b0, 1, "add_after_flush");
        handoff("add_after_flush");

        // Reset in the middle of a divide.
        alu_operation_type = 4'hA;
        alu_a              = 32'd1000;
        alu_b              = 32'd3;
        in_valid           = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_div");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("reset_div_no_out", 32'(seen), 32'd0);
        op_wait(4'h6, 32'd3, 32'd10, 1'b0, 1, "sub_after_reset");
        handoff("sub_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the core's combinational ALU. It has the same 4-bit operation encoding and comparison flags. Width is set by `XLEN`, and the operand/result path uses a valid/ready handshake. Operations complete at different speeds:
- Logic, add, sub and shift ops complete in one cycle.
- Multiplies go through a configurable pipeline.
- Divide and remainder use an iterative radix-2 divider.

It sits in the execute stage. The pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32: operand and result width. Must be ≥ 8 and a power of two.
- `MUL_STAGES`, 2: register stages in the multiply path, ≥ 1.
- `clk` input 1: the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: the block can accept an operation.
- `alu_a` input XLEN: operand A.
- `alu_b` input XLEN: operand B.
- `alu_operation_type` input 4: opcode, encoding per `alu_pkg::alu_op_e`.
- `comparison_mode` input 1: selects the comparison type. 1 = unsigned, 0 = signed.
- `flush` input 1: abandon any in-flight operation.
- `out_valid` output 1: result is available.
- `out_ready` input 1: the consumer takes the result.
- `alu_result` output XLEN: result.
- `comparison_flags` output 3: [2] a<b, [1] a>b, [0] a==b.
- `busy` output 1: the state is not IDLE.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE.
- **Accept rule:** `in_ready` = (state==IDLE). An operation is accepted when `in_valid && in_ready`. At accept, the operands, opcode and mode are captured.
- **Single-cycle ops (0x0–0x7: xor, and, add, sll, srl, sra, sub, or):** the result is computed at accept. The FSM goes IDLE→DONE.
- **Shifts:** the shift amount is `alu_b[$clog2(XLEN)-1:0]`. Upper bits are ignored. `sra` is a true arithmetic shift of signed A.
- **Multiply (0x8 mul low, 0xD mulh s×s, 0xE mulhsu s×u, 0xF mulhu u×u):**
  - Operands are sign- or zero-extended to XLEN+1 bits. A 2·XLEN product is formed.
  - 0x8 returns bits [XLEN-1:0]. The others return [2·XLEN-1:XLEN].
  - The FSM goes IDLE→MUL, counts `MUL_STAGES` cycles, then goes →DONE.
- **Divide (0x9 div, 0xA divu, 0xB rem, 0xC remu):**
  - **Zero divisor:** if `alu_b`==0 at accept, the result is 0 and the FSM goes IDLE→DONE directly. This matches the existing ALU.
  - **Signed overflow:** for a signed op with A = most-negative and B = −1, the result is div → A and rem → 0. The FSM goes IDLE→DONE directly.
  - **Otherwise:** IDLE→DIV. The sub-module works on absolute values for XLEN iteration cycles plus one sign-fixup cycle, then the FSM goes →DONE.
  - **Sign rules:** the quotient is negative iff the operand signs differ. The remainder takes the sign of the dividend.
- **Comparison flags:** computed from the captured operands and `comparison_mode`, for every opcode. They are registered alongside `alu_result`.
- **Output hold:** in DONE, `out_valid`=1. `alu_result` and `comparison_flags` hold stable until `out_valid && out_ready`, then the FSM goes →IDLE.
- **Invalid opcode:** none exist; all 16 encodings are defined.
- **Flush:**
  - In MUL, DIV or DONE, `flush` forces →IDLE on the next edge with no output. In DONE the pending result is dropped.
  - In IDLE, `flush` has priority over accept: `in_ready` stays 1, but no operation is taken that cycle.

## Timing
- **Reset:** all registers are cleared asynchronously. State is IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `alu_result`=0, `comparison_flags`=0.
- **Latency:** counted from the accept edge to the first cycle `out_valid`=1.
  - Single-cycle ops, div by zero and signed overflow: 1 cycle.
  - Multiply: 1+`MUL_STAGES` cycles (3 at the defaults).
  - Divide: XLEN+2 cycles (34 at XLEN=32).
- **Throughput:** one operation per latency+1 cycles when `out_ready` is held at 1. There is no accept in the same cycle as the result handoff.
- **Outputs:** `in_ready`, `out_valid` and `busy` are Moore outputs, decoded from the state register only.
- **Operand stability:** operands may change on any cycle after accept without affecting the in-flight operation.
- **Reset mid-operation:** aborts immediately. No `out_valid` is produced.

## Structure
- **`alu_pkg` (shared package)** holds:
  - `alu_op_e`: 4-bit opcode enum reusing the existing encoding.
  - `alu_state_e`.
  - Helper function `is_mul(op)` / `is_div(op)`.
  - Flag bit index constants `CMP_LT`=2, `CMP_GT`=1, `CMP_EQ`=0.
- **Sub-module `alu_div_iter #(XLEN)`:** restoring radix-2 divider. Interface: start/done handshake, `signed_op`, `rem_sel`, and internal iteration counter and sign-fixup stage. Instantiated once.
- **Multiply path:** inline shift-register pipeline of depth `MUL_STAGES`. The product is registered and the valid bit travels along the pipeline.

## Test plan
- **Add with flags:** reset, then add A=5, B=7 with `out_ready`=1 → `out_valid` one cycle after accept, result=12, flags=3'b100; `in_ready` is back to 1 the following cycle.
- **Multiply (defaults):** mulh A=0x8000_0000, B=2 → after 3 cycles result=0xFFFF_FFFF. Same operands with mulhu → 0x0000_0001. mul → 0x0000_0000.
- **Divide:** div A=−7, B=2 → after 34 cycles result=−3. rem → −1. divu A=100, B=7 → 14, remu → 2.
- **Divide corner cases:** divu A=9, B=0 → result 0 after 1 cycle. div A=0x8000_0000, B=−1 → 0x8000_0000. rem with the same operands → 0.
- **Backpressure and flags:** hold `out_ready`=0 for 5 cycles after an xor result → result and flags stable, `in_ready`=0, and a new `in_valid` is ignored. Then set `comparison_mode`=1 with A=0xFFFF_FFFF, B=1 → flags=3'b010; in signed mode → 3'b100.
- **Flush and reset mid-divide:** assert `flush` at cycle 10 of a divide → IDLE next cycle, no `out_valid`, and a following add completes normally. Deassert `rst_n` mid-divide → all outputs at reset values immediately.
